// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: RV32I memory stage with EX/MEM and MEM/WB registers and a req/ack load/store unit
module mem_stage_lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        sys_clk,
  input  logic        sys_arstn,
  input  logic [4:0]  ex_Rd_i,
  input  logic [14:0] mem_ctrl_i,
  input  logic [1:0]  wb_ctrl_i,
  input  logic [31:0] result_i,
  input  logic [31:0] reg2_r_data_i,
  output logic [4:0]  mem_Rd_o,
  output logic [1:0]  mem_wb_ctrl_o,
  output logic [31:0] mem_data_o,
  output logic [4:0]  wb_Rd_o,
  output logic [1:0]  wb_ctrl_o,
  output logic [31:0] wb_data_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_ack_i,
  output logic        hold_o,
  output logic        misalign_o,
  output logic        bus_err_o
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;
  logic [0:0] state;
  logic [7:0] cnt;
  logic [2:0] ex_f3;
  logic ex_rd_en, ex_wr_en;
  logic [31:0] ex_sd;
  logic busy, ack, tmo, in_go, ex_bad;
  logic [1:0] a;
  logic [3:0] be;
  logic [31:0] wdata, lane, ld;
  logic unused;

  function automatic logic bad_op(input logic [2:0] f, input logic [1:0] al);
    return f == 3'b011 || f[2:1] == 2'b11 || (f[1:0] == 2'b01 && al[0]) || (f[1:0] == 2'b10 && al != 2'b00);
  endfunction

  assign unused = ^{mem_ctrl_i[14:6], mem_ctrl_i[3]};
  assign a = mem_data_o[1:0];
  assign busy = state == ACCESS;
  assign ack = busy & dbus_ack_i;
  assign tmo = busy & ~dbus_ack_i & (cnt == 8'(TIMEOUT - 1));
  assign hold_o = busy & ~dbus_ack_i & ~tmo;
  assign bus_err_o = tmo;
  assign in_go = (mem_ctrl_i[4] | mem_ctrl_i[5]) & ~bad_op(mem_ctrl_i[2:0], result_i[1:0]);
  assign ex_bad = (ex_rd_en | ex_wr_en) & bad_op(ex_f3, a);
  assign misalign_o = ~busy & ex_bad;
  assign be = ex_f3[1] ? 4'b1111 : ex_f3[0] ? (a[1] ? 4'b1100 : 4'b0011) : 4'b0001 << a;
  assign wdata = ex_f3[1] ? ex_sd : ex_f3[0] ? {2{ex_sd[15:0]}} : {4{ex_sd[7:0]}};
  assign lane = dbus_rdata_i >> {a, 3'b000};
  assign ld = ex_f3[1] ? dbus_rdata_i :
              ex_f3[0] ? {{16{~ex_f3[2] & lane[15]}}, lane[15:0]} :
                         {{24{~ex_f3[2] & lane[7]}}, lane[7:0]};
  assign dbus_req_o = busy;
  assign dbus_we_o = busy & ex_wr_en;
  assign dbus_addr_o = busy ? {mem_data_o[31:2], 2'b00} : 32'd0;
  assign dbus_be_o = busy ? be : 4'd0;
  assign dbus_wdata_o = busy ? wdata : 32'd0;

  // EX/MEM register: captures the execute stage whenever the pipeline is not held
  always_ff @(posedge sys_clk) begin
    if (!sys_arstn) begin
      mem_Rd_o <= '0;
      mem_wb_ctrl_o <= '0;
      mem_data_o <= '0;
      ex_f3 <= '0;
      ex_rd_en <= 1'b0;
      ex_wr_en <= 1'b0;
      ex_sd <= '0;
    end else if (!hold_o) begin
      mem_Rd_o <= ex_Rd_i;
      mem_wb_ctrl_o <= wb_ctrl_i;
      mem_data_o <= result_i;
      ex_f3 <= mem_ctrl_i[2:0];
      ex_rd_en <= mem_ctrl_i[4];
      ex_wr_en <= mem_ctrl_i[5];
      ex_sd <= reg2_r_data_i;
    end
  end

  // Access FSM: a new access starts whenever an aligned memory op is captured, so back-to-back ops need no bubble
  always_ff @(posedge sys_clk) begin
    if (!sys_arstn) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= hold_o ? state : (in_go ? ACCESS : IDLE);
      cnt <= hold_o ? cnt + 8'd1 : 8'd0;
    end
  end

  // MEM/WB register: completed ops write back, aborted ops lose their write enable, stalls insert bubbles
  always_ff @(posedge sys_clk) begin
    if (!sys_arstn) begin
      wb_Rd_o <= '0;
      wb_ctrl_o <= '0;
      wb_data_o <= '0;
    end else if (hold_o) begin
      wb_Rd_o <= '0;
      wb_ctrl_o <= '0;
      wb_data_o <= '0;
    end else begin
      wb_Rd_o <= mem_Rd_o;
      wb_ctrl_o <= (ex_bad | tmo) ? 2'b00 : mem_wb_ctrl_o;
      wb_data_o <= (ack & mem_wb_ctrl_o[0]) ? ld : mem_data_o;
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed and random checks of the memory stage against a per-op behavioural model
module tb_mem_stage_lsu;
  localparam int TO = 4;
  logic sys_clk = 1'b0, sys_arstn = 1'b0;
  logic [4:0] ex_Rd_i, mem_Rd_o, wb_Rd_o;
  logic [14:0] mem_ctrl_i;
  logic [1:0] wb_ctrl_i, mem_wb_ctrl_o, wb_ctrl_o;
  logic [31:0] result_i, reg2_r_data_i, mem_data_o, wb_data_o, dbus_addr_o, dbus_wdata_o, dbus_rdata_i;
  logic dbus_req_o, dbus_we_o, dbus_ack_i, hold_o, misalign_o, bus_err_o;
  logic [3:0] dbus_be_o;
  int n_chk = 0, n_fail = 0;

  typedef struct packed {
    logic [4:0] rd;
    logic [14:0] mc;
    logic [1:0] wb;
    logic [31:0] res, sd, rdata;
    logic [7:0] lat;
  } op_t;

  op_t q[$];
  op_t cur, nop;
  int w;
  logic [4:0] e_rd;
  logic [1:0] e_ctl;
  logic [31:0] e_dat;
  bit e_full;

  always #5 sys_clk = ~sys_clk;

  mem_stage_lsu #(.TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_arstn(sys_arstn), .ex_Rd_i(ex_Rd_i), .mem_ctrl_i(mem_ctrl_i),
    .wb_ctrl_i(wb_ctrl_i), .result_i(result_i), .reg2_r_data_i(reg2_r_data_i),
    .mem_Rd_o(mem_Rd_o), .mem_wb_ctrl_o(mem_wb_ctrl_o), .mem_data_o(mem_data_o),
    .wb_Rd_o(wb_Rd_o), .wb_ctrl_o(wb_ctrl_o), .wb_data_o(wb_data_o),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o), .dbus_rdata_i(dbus_rdata_i),
    .dbus_ack_i(dbus_ack_i), .hold_o(hold_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic op_t mk(input logic [4:0] rd, input logic [2:0] f3, input bit rd_en, input bit wr_en,
                             input logic [1:0] wb, input logic [31:0] res, input logic [31:0] sd,
                             input logic [31:0] rdata, input int lat);
    op_t o;
    o.rd = rd;
    o.mc = 15'($urandom);
    o.mc[2:0] = f3;
    o.mc[4] = rd_en;
    o.mc[5] = wr_en;
    o.wb = wb;
    o.res = res;
    o.sd = sd;
    o.rdata = rdata;
    o.lat = 8'(lat);
    return o;
  endfunction

  function automatic bit legal(input logic [2:0] f, input logic [1:0] al);
    case (f)
      3'd0, 3'd4: return 1'b1;
      3'd1, 3'd5: return al % 2 == 0;
      3'd2: return al == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ldval(input logic [2:0] f, input logic [1:0] al, input logic [31:0] d);
    logic [31:0] v;
    v = d >> (8 * al);
    if (f[1:0] == 2'd0) begin
      v = v & 32'hff;
      if (f == 3'd0 && v >= 128) v = v - 256;
    end else if (f[1:0] == 2'd1) begin
      v = v & 32'hffff;
      if (f == 3'd1 && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f, input logic [1:0] al);
    return f[1:0] == 2'd0 ? 4'(1 << al) : f[1:0] == 2'd1 ? 4'(3 << al) : 4'd15;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] f, input logic [31:0] sd);
    return f[1:0] == 2'd0 ? (sd & 32'hff) * 32'h01010101 : f[1:0] == 2'd1 ? (sd & 32'hffff) * 32'h00010001 : sd;
  endfunction

  task automatic drive(input op_t o);
    ex_Rd_i = o.rd;
    mem_ctrl_i = o.mc;
    wb_ctrl_i = o.wb;
    result_i = o.res;
    reg2_r_data_i = o.sd;
  endtask

  task automatic model_reset();
    cur = nop;
    w = 0;
    e_rd = '0;
    e_ctl = '0;
    e_dat = '0;
    e_full = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, 32'(dbus_req_o), 0);
    chk({tag, "_hold"}, 32'(hold_o), 0);
    chk({tag, "_addr"}, dbus_addr_o, 0);
    chk({tag, "_be"}, 32'(dbus_be_o), 0);
    chk({tag, "_we"}, 32'(dbus_we_o), 0);
    chk({tag, "_mis"}, 32'(misalign_o), 0);
    chk({tag, "_berr"}, 32'(bus_err_o), 0);
    chk({tag, "_mem_rd"}, 32'(mem_Rd_o), 0);
    chk({tag, "_mem_data"}, mem_data_o, 0);
    chk({tag, "_wb_rd"}, 32'(wb_Rd_o), 0);
    chk({tag, "_wb_ctl"}, 32'(wb_ctrl_o), 0);
    chk({tag, "_wb_data"}, wb_data_o, 0);
  endtask

  task automatic step();
    op_t nx;
    bit mem, ok, req, ack, to, hold;
    logic [2:0] f;
    logic [1:0] al;
    @(negedge sys_clk);
    f = cur.mc[2:0];
    al = cur.res[1:0];
    mem = cur.mc[4] | cur.mc[5];
    ok = legal(f, al);
    req = mem && ok;
    ack = req && w == int'(cur.lat);
    to = req && !ack && w == TO - 1;
    hold = req && !ack && !to;
    dbus_ack_i = ack;
    dbus_rdata_i = ack ? cur.rdata : $urandom;
    #1;
    chk("hold", 32'(hold_o), 32'(hold));
    chk("req", 32'(dbus_req_o), 32'(req));
    chk("misalign", 32'(misalign_o), 32'(mem && !ok));
    chk("bus_err", 32'(bus_err_o), 32'(to));
    chk("mem_rd", 32'(mem_Rd_o), 32'(cur.rd));
    chk("mem_wbctl", 32'(mem_wb_ctrl_o), 32'(cur.wb));
    chk("mem_data", mem_data_o, cur.res);
    chk("wb_ctl", 32'(wb_ctrl_o), 32'(e_ctl));
    if (e_full) begin
      chk("wb_rd", 32'(wb_Rd_o), 32'(e_rd));
      chk("wb_data", wb_data_o, e_dat);
    end
    if (req) begin
      chk("addr", dbus_addr_o, cur.res & ~32'd3);
      chk("we", 32'(dbus_we_o), 32'(cur.mc[5]));
      chk("be", 32'(dbus_be_o), 32'(exp_be(f, al)));
      if (cur.mc[5]) chk("wdata", dbus_wdata_o, exp_wd(f, cur.sd));
    end
    nx = nop;
    if (!hold) begin
      if (q.size() > 0) nx = q.pop_front();
      drive(nx);
    end
    @(posedge sys_clk);
    if (hold) begin
      e_rd = '0;
      e_ctl = '0;
      e_dat = '0;
      e_full = 1'b1;
      w++;
    end else begin
      e_rd = cur.rd;
      e_ctl = (mem && (!ok || to)) ? 2'b00 : cur.wb;
      e_dat = (ack && cur.wb[0]) ? ldval(f, al, cur.rdata) : cur.res;
      e_full = !(mem && (!ok || to));
      cur = nx;
      w = 0;
    end
  endtask

  function automatic op_t rnd_op();
    int k;
    logic [31:0] res;
    k = $urandom_range(0, 2);
    res = $urandom;
    if (k == 0) return mk(5'($urandom), 3'($urandom), 1'b0, 1'b0, {1'($urandom), 1'b0}, res, $urandom, 0, 0);
    if (k == 1) return mk(5'($urandom), 3'($urandom_range(0, 7)), 1'b1, 1'b0, 2'b11, res, $urandom, $urandom,
                          $urandom_range(0, 5));
    return mk(5'($urandom), 3'($urandom_range(0, 2)), 1'($urandom), 1'b1, 2'b00, res, $urandom, $urandom,
              $urandom_range(0, 5));
  endfunction

  initial begin
    nop = '0;
    drive(nop);
    dbus_ack_i = 1'b0;
    dbus_rdata_i = '0;
    model_reset();
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    #1;
    chk_zero("reset");
    sys_arstn = 1'b1;
    q.push_back(mk(5'd5, 3'd0, 1'b0, 1'b0, 2'b10, 32'h0000_1234, 32'd0, 32'd0, 0));
    q.push_back(mk(5'd6, 3'd0, 1'b1, 1'b0, 2'b11, 32'h0000_1003, 32'd0, 32'h80FF_FFFF, 3));
    q.push_back(mk(5'd0, 3'd1, 1'b0, 1'b1, 2'b00, 32'h0000_2002, 32'h0000_ABCD, 32'd0, 0));
    q.push_back(mk(5'd7, 3'd2, 1'b1, 1'b0, 2'b11, 32'h0000_3000, 32'd0, 32'hDEAD_BEEF, 1));
    q.push_back(mk(5'd8, 3'd2, 1'b1, 1'b0, 2'b11, 32'h0000_3001, 32'd0, 32'd0, 0));
    q.push_back(mk(5'd9, 3'd2, 1'b1, 1'b0, 2'b11, 32'h0000_4000, 32'd0, 32'd0, 100));
    q.push_back(mk(5'd10, 3'd4, 1'b1, 1'b0, 2'b11, 32'h0000_5002, 32'd0, 32'h00F1_0000, 0));
    q.push_back(mk(5'd11, 3'd5, 1'b1, 1'b0, 2'b11, 32'h0000_5002, 32'd0, 32'h8001_0000, 2));
    q.push_back(mk(5'd12, 3'd1, 1'b1, 1'b0, 2'b11, 32'h0000_5002, 32'd0, 32'h8001_0000, 0));
    q.push_back(mk(5'd13, 3'd3, 1'b1, 1'b0, 2'b11, 32'h0000_6000, 32'd0, 32'd0, 0));
    q.push_back(mk(5'd14, 3'd0, 1'b1, 1'b1, 2'b00, 32'h0000_7001, 32'h0000_0055, 32'd0, 1));
    q.push_back(mk(5'd15, 3'd0, 1'b0, 1'b0, 2'b10, 32'hCAFE_0000, 32'd0, 32'd0, 0));
    for (int i = 0; i < 500 && q.size() > 0; i++) step();
    repeat (4) step();
    q.push_back(mk(5'd20, 3'd2, 1'b1, 1'b0, 2'b11, 32'h0000_8000, 32'd0, 32'd0, 100));
    step();
    step();
    @(negedge sys_clk);
    dbus_ack_i = 1'b0;
    #1;
    chk("rst_mid_req_before", 32'(dbus_req_o), 1);
    chk("rst_mid_hold_before", 32'(hold_o), 1);
    sys_arstn = 1'b0;
    drive(nop);
    @(posedge sys_clk);
    @(negedge sys_clk);
    #1;
    chk_zero("rst_mid");
    model_reset();
    sys_arstn = 1'b1;
    for (int i = 0; i < 250; i++) q.push_back(rnd_op());
    for (int i = 0; i < 5000 && q.size() > 0; i++) step();
    repeat (8) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
